// File: rtl/jtag_tap_target_pkg.sv
// Shared JTAG TAP definitions: one-hot TAP_* state codes and the IEEE 1149.1 next-state function.
// The host FSM and the target use this same encoding.
package jtag_tap_target_pkg;

  localparam int unsigned IDCODE_LEN = 32;

  typedef enum logic [15:0] {
    TAP_TEST_LOGIC_RESET = 16'h0001,
    TAP_RUN_TEST_IDLE    = 16'h0002,
    TAP_SELECT_DR        = 16'h0004,
    TAP_CAPTURE_DR       = 16'h0008,
    TAP_SHIFT_DR         = 16'h0010,
    TAP_EXIT1_DR         = 16'h0020,
    TAP_PAUSE_DR         = 16'h0040,
    TAP_EXIT2_DR         = 16'h0080,
    TAP_UPDATE_DR        = 16'h0100,
    TAP_SELECT_IR        = 16'h0200,
    TAP_CAPTURE_IR       = 16'h0400,
    TAP_SHIFT_IR         = 16'h0800,
    TAP_EXIT1_IR         = 16'h1000,
    TAP_PAUSE_IR         = 16'h2000,
    TAP_EXIT2_IR         = 16'h4000,
    TAP_UPDATE_IR        = 16'h8000
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_USER
  } dr_sel_e;

  function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
    tap_state_e nxt;
    case (state)
      TAP_TEST_LOGIC_RESET: nxt = tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
      TAP_RUN_TEST_IDLE:    nxt = tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
      TAP_SELECT_DR:        nxt = tms ? TAP_SELECT_IR        : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR:       nxt = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
      TAP_SHIFT_DR:         nxt = tms ? TAP_EXIT1_DR         : TAP_SHIFT_DR;
      TAP_EXIT1_DR:         nxt = tms ? TAP_UPDATE_DR        : TAP_PAUSE_DR;
      TAP_PAUSE_DR:         nxt = tms ? TAP_EXIT2_DR         : TAP_PAUSE_DR;
      TAP_EXIT2_DR:         nxt = tms ? TAP_UPDATE_DR        : TAP_SHIFT_DR;
      TAP_UPDATE_DR:        nxt = tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
      TAP_SELECT_IR:        nxt = tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR:       nxt = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
      TAP_SHIFT_IR:         nxt = tms ? TAP_EXIT1_IR         : TAP_SHIFT_IR;
      TAP_EXIT1_IR:         nxt = tms ? TAP_UPDATE_IR        : TAP_PAUSE_IR;
      TAP_PAUSE_IR:         nxt = tms ? TAP_EXIT2_IR         : TAP_PAUSE_IR;
      TAP_EXIT2_IR:         nxt = tms ? TAP_UPDATE_IR        : TAP_SHIFT_IR;
      TAP_UPDATE_IR:        nxt = tms ? TAP_SELECT_DR        : TAP_RUN_TEST_IDLE;
      default:              nxt = TAP_TEST_LOGIC_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_target_if.sv
// JTAG pin bundle between a TAP host (master) and a TAP target (slave).
interface jtag_tap_target_if;
  logic tck;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_oe;

  modport master (output tck, output tms, output tdi, input tdo, input tdo_oe);
  modport slave  (input tck, input tms, input tdi, output tdo, output tdo_oe);
endinterface

// File: rtl/jtag_edge_sync.sv
// Two-flop synchronisers for tck/tms/tdi plus registered tck rise/fall pulses;
// tms_s/tdi_s are aligned with the pulses, three clk after the pin edge.
module jtag_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic tck,
  input  logic tms,
  input  logic tdi,
  output logic tck_rise,
  output logic tck_fall,
  output logic tms_s,
  output logic tdi_s
);

  logic [1:0] tck_meta;
  logic [1:0] tms_meta;
  logic [1:0] tdi_meta;
  logic       tck_d;

  // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain really is N stages deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_meta <= 2'b00;
      tms_meta <= 2'b00;
      tdi_meta <= 2'b00;
      tck_d    <= 1'b0;
      tck_rise <= 1'b0;
      tck_fall <= 1'b0;
      tms_s    <= 1'b0;
      tdi_s    <= 1'b0;
    end else begin
      tck_meta <= {tck_meta[0], tck};
      tms_meta <= {tms_meta[0], tms};
      tdi_meta <= {tdi_meta[0], tdi};
      tck_d    <= tck_meta[1];
      tck_rise <= tck_meta[1] & ~tck_d;
      tck_fall <= ~tck_meta[1] & tck_d;
      tms_s    <= tms_meta[1];
      tdi_s    <= tdi_meta[1];
    end
  end

endmodule

// File: rtl/jtag_tap_target.sv
// Device-side JTAG TAP: oversampled 16-state controller with IR, IDCODE, BYPASS and a user DR.
// Optional macro JTAG_TARGET_TRST_EN adds the synchronised active-low trst_n port.
module jtag_tap_target
  import jtag_tap_target_pkg::*;
#(
  parameter int unsigned       IR_LEN      = 10,
  parameter logic [31:0]       IDCODE_VAL  = 32'h0A01_0C3D,
  parameter logic [IR_LEN-1:0] IR_IDCODE   = IR_LEN'('h003),
  parameter logic [IR_LEN-1:0] IR_USER     = IR_LEN'('h020),
  parameter int unsigned       USER_DR_LEN = 32
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef JTAG_TARGET_TRST_EN
  input  logic                   trst_n,
`endif
  jtag_tap_target_if.slave       jtag,
  output logic [15:0]            tap_state,
  output logic [IR_LEN-1:0]      ir_value,
  input  logic [USER_DR_LEN-1:0] user_capture_data,
  output logic [USER_DR_LEN-1:0] user_update_data,
  output logic                   user_update_pulse,
  output logic                   tlr_pulse
);

  logic tck_rise;
  logic tck_fall;
  logic tms_s;
  logic tdi_s;

  jtag_edge_sync u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .tck      (jtag.tck),
    .tms      (jtag.tms),
    .tdi      (jtag.tdi),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall),
    .tms_s    (tms_s),
    .tdi_s    (tdi_s)
  );

  logic force_tlr;

`ifdef JTAG_TARGET_TRST_EN
  logic [1:0] trst_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trst_sync <= 2'b11;
    else     trst_sync <= {trst_sync[0], trst_n};
  end

  assign force_tlr = ~trst_sync[1];
`else
  assign force_tlr = 1'b0;
`endif

  tap_state_e state_q;
  tap_state_e state_d;
  logic       enter_tlr;

  // NOTE: every signal driven by an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (force_tlr)     state_d = TAP_TEST_LOGIC_RESET;
    else if (tck_rise) state_d = tap_next(state_q, tms_s);
    enter_tlr = (state_d == TAP_TEST_LOGIC_RESET) && (state_q != TAP_TEST_LOGIC_RESET);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= TAP_TEST_LOGIC_RESET;
    else     state_q <= state_d;
  end

  assign tap_state = state_q;

  dr_sel_e dr_sel;

  always_comb begin
    dr_sel = DR_BYPASS;
    if (ir_value == IR_IDCODE)    dr_sel = DR_IDCODE;
    else if (ir_value == IR_USER) dr_sel = DR_USER;
  end

  logic [IR_LEN-1:0]      ir_shift;
  logic [IDCODE_LEN-1:0]  idcode_dr;
  logic [USER_DR_LEN-1:0] user_dr;
  logic                   bypass_dr;

  // NOTE: shift registers are reset too, so a reset mid-shift leaves no partial contents behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_shift          <= '0;
      idcode_dr         <= '0;
      user_dr           <= '0;
      bypass_dr         <= 1'b0;
      ir_value          <= IR_IDCODE;
      user_update_data  <= '0;
      user_update_pulse <= 1'b0;
      tlr_pulse         <= 1'b0;
    end else begin
      user_update_pulse <= 1'b0;
      tlr_pulse         <= enter_tlr;
      if (enter_tlr) begin
        ir_value <= IR_IDCODE;
      end else if (tck_rise) begin
        // Actions are keyed on the state being left, not the one being entered.
        case (state_q)
          TAP_CAPTURE_IR: ir_shift <= IR_LEN'(2'b01);
          TAP_SHIFT_IR:   ir_shift <= {tdi_s, ir_shift[IR_LEN-1:1]};
          TAP_UPDATE_IR:  ir_value <= ir_shift;
          TAP_CAPTURE_DR: begin
            case (dr_sel)
              DR_IDCODE: idcode_dr <= IDCODE_VAL;
              DR_USER:   user_dr   <= user_capture_data;
              default:   bypass_dr <= 1'b0;
            endcase
          end
          TAP_SHIFT_DR: begin
            case (dr_sel)
              DR_IDCODE: idcode_dr <= {tdi_s, idcode_dr[IDCODE_LEN-1:1]};
              DR_USER:   user_dr   <= (user_dr >> 1) | (USER_DR_LEN'(tdi_s) << (USER_DR_LEN - 1));
              default:   bypass_dr <= tdi_s;
            endcase
          end
          TAP_UPDATE_DR: begin
            if (dr_sel == DR_USER) begin
              user_update_data  <= user_dr;
              user_update_pulse <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic dr_out;

  always_comb begin
    dr_out = bypass_dr;
    case (dr_sel)
      DR_IDCODE: dr_out = idcode_dr[0];
      DR_USER:   dr_out = user_dr[0];
      default:   dr_out = bypass_dr;
    endcase
  end

  logic tdo_q;
  logic tdo_oe_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdo_q    <= 1'b0;
      tdo_oe_q <= 1'b0;
    end else if (tck_fall) begin
      case (state_q)
        TAP_SHIFT_IR: begin
          tdo_q    <= ir_shift[0];
          tdo_oe_q <= 1'b1;
        end
        TAP_SHIFT_DR: begin
          tdo_q    <= dr_out;
          tdo_oe_q <= 1'b1;
        end
        default: begin
          tdo_q    <= 1'b0;
          tdo_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign jtag.tdo    = tdo_q;
  assign jtag.tdo_oe = tdo_oe_q;

endmodule

// File: tb/tb_jtag_tap_target.sv
// Directed bench for jtag_tap_target: reset, IDCODE, BYPASS, user DR, TLR entry and mid-shift reset.
// Build with JTAG_TARGET_TRST_EN defined to also exercise trst_n.
module tb_jtag_tap_target;
  import jtag_tap_target_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  ir_value;
  logic [15:0] tap_state;
  logic [31:0] user_capture_data = '0;
  logic [31:0] user_update_data;
  logic        user_update_pulse;
  logic        tlr_pulse;
`ifdef JTAG_TARGET_TRST_EN
  logic        trst_n = 1'b1;
`endif

  int tests_run = 0;
  int failures  = 0;
  int tlr_cnt   = 0;
  int upd_cnt   = 0;

  jtag_tap_target_if jtag_bus ();

  jtag_tap_target dut (
    .clk               (clk),
    .rst               (rst),
`ifdef JTAG_TARGET_TRST_EN
    .trst_n            (trst_n),
`endif
    .jtag              (jtag_bus),
    .tap_state         (tap_state),
    .ir_value          (ir_value),
    .user_capture_data (user_capture_data),
    .user_update_data  (user_update_data),
    .user_update_pulse (user_update_pulse),
    .tlr_pulse         (tlr_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tlr_pulse === 1'b1)         tlr_cnt++;
    if (user_update_pulse === 1'b1) upd_cnt++;
  end

  // One TCK period: tms/tdi set after the fall, tdo/tdo_oe sampled just before the rise.
  task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v, output logic oe_v);
    @(negedge clk);
    jtag_bus.tms = tms_v;
    jtag_bus.tdi = tdi_v;
    repeat (6) @(negedge clk);
    tdo_v = jtag_bus.tdo;
    oe_v  = jtag_bus.tdo_oe;
    jtag_bus.tck = 1'b1;
    repeat (6) @(negedge clk);
    jtag_bus.tck = 1'b0;
  endtask

  task automatic move(input logic tms_v);
    logic d, o;
    tck_cycle(tms_v, 1'b0, d, o);
  endtask

  // From RTI: load a 10-bit IR LSB first and return to RTI; returns TDO seen during the shift.
  task automatic load_ir(input logic [9:0] val, output logic [9:0] tdo_bits);
    logic o;
    move(1'b1); move(1'b1); move(1'b0); move(1'b0);
    for (int i = 0; i < 10; i++) tck_cycle(i == 9, val[i], tdo_bits[i], o);
    move(1'b1); move(1'b0);
  endtask

  // From RTI: capture, shift len bits, update, back to RTI.
  task automatic shift_dr(input logic [31:0] din, input int len, output logic [31:0] dout,
                          output logic oe_before, output logic oe_all, output logic oe_after);
    logic d, o;
    dout   = '0;
    oe_all = 1'b1;
    move(1'b1); move(1'b0);
    tck_cycle(1'b0, 1'b0, d, oe_before);
    for (int i = 0; i < len; i++) begin
      tck_cycle(i == len - 1, din[i], dout[i], o);
      if (o !== 1'b1) oe_all = 1'b0;
    end
    tck_cycle(1'b1, 1'b0, d, oe_after);
    move(1'b0);
  endtask

  task automatic test_reset();
    int tlr0;
    jtag_bus.tck = 1'b0; jtag_bus.tms = 1'b1; jtag_bus.tdi = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tlr0 = tlr_cnt;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++; if (tap_state !== TAP_TEST_LOGIC_RESET) begin failures++; $display("FAIL reset_state got %h want %h", tap_state, TAP_TEST_LOGIC_RESET); end
    tests_run++; if (ir_value !== 10'h003) begin failures++; $display("FAIL reset_ir got %h want 003", ir_value); end
    tests_run++; if ({jtag_bus.tdo, jtag_bus.tdo_oe} !== 2'b00) begin failures++; $display("FAIL reset_tdo got tdo=%b oe=%b want 0 0", jtag_bus.tdo, jtag_bus.tdo_oe); end
    tests_run++; if (user_update_data !== 32'h0) begin failures++; $display("FAIL reset_user got %h want 0", user_update_data); end
    tests_run++; if ({user_update_pulse, tlr_pulse} !== 2'b00) begin failures++; $display("FAIL reset_pulses got %b want 00", {user_update_pulse, tlr_pulse}); end
    tests_run++; if (tlr_cnt - tlr0 !== 0) begin failures++; $display("FAIL reset_no_tlr_pulse got %0d want 0", tlr_cnt - tlr0); end
    move(1'b0);
    tests_run++; if (tap_state !== TAP_RUN_TEST_IDLE) begin failures++; $display("FAIL reset_to_rti got %h want %h", tap_state, TAP_RUN_TEST_IDLE); end
  endtask

  task automatic test_idcode();
    logic [31:0] dout;
    logic ob, oa, oall;
    shift_dr(32'h0, 32, dout, ob, oall, oa);
    tests_run++; if (dout !== 32'h0A01_0C3D) begin failures++; $display("FAIL idcode_tdo got %h want 0a010c3d", dout); end
    tests_run++; if ({ob, oall, oa} !== 3'b010) begin failures++; $display("FAIL idcode_oe got before=%b during=%b after=%b want 0 1 0", ob, oall, oa); end
    tests_run++; if (tap_state !== TAP_RUN_TEST_IDLE) begin failures++; $display("FAIL idcode_end_state got %h want %h", tap_state, TAP_RUN_TEST_IDLE); end
  endtask

  task automatic test_bypass();
    logic [9:0]  irt;
    logic [31:0] dout;
    logic ob, oa, oall;
    int upd0;
    load_ir(10'h3FF, irt);
    tests_run++; if (ir_value !== 10'h3FF) begin failures++; $display("FAIL bypass_ir got %h want 3ff", ir_value); end
    tests_run++; if (irt[1:0] !== 2'b01) begin failures++; $display("FAIL ir_capture_bits got %b want 01", irt[1:0]); end
    upd0 = upd_cnt;
    shift_dr(32'h0000_000D, 4, dout, ob, oall, oa);
    tests_run++; if (dout[3:0] !== 4'b1010) begin failures++; $display("FAIL bypass_tdo got %b want 1010", dout[3:0]); end
    tests_run++; if (oall !== 1'b1) begin failures++; $display("FAIL bypass_oe got %b want 1", oall); end
    tests_run++; if (upd_cnt - upd0 !== 0 || user_update_data !== 32'h0) begin failures++; $display("FAIL bypass_no_update got pulses=%0d data=%h want 0 0", upd_cnt - upd0, user_update_data); end
  endtask

  task automatic test_user();
    logic [9:0]  irt;
    logic [31:0] dout;
    logic ob, oa, oall;
    int upd0;
    user_capture_data = 32'hDEAD_BEEF;
    load_ir(10'h020, irt);
    tests_run++; if (ir_value !== 10'h020) begin failures++; $display("FAIL user_ir got %h want 020", ir_value); end
    upd0 = upd_cnt;
    shift_dr(32'h1234_5678, 32, dout, ob, oall, oa);
    tests_run++; if (dout !== 32'hDEAD_BEEF) begin failures++; $display("FAIL user_tdo got %h want deadbeef", dout); end
    tests_run++; if (user_update_data !== 32'h1234_5678) begin failures++; $display("FAIL user_update got %h want 12345678", user_update_data); end
    tests_run++; if (upd_cnt - upd0 !== 1) begin failures++; $display("FAIL user_pulse_count got %0d want 1", upd_cnt - upd0); end
  endtask

  task automatic test_tlr();
    int tlr0;
    tlr0 = tlr_cnt;
    for (int i = 0; i < 5; i++) move(1'b1);
    tests_run++; if (tap_state !== TAP_TEST_LOGIC_RESET) begin failures++; $display("FAIL tlr_state got %h want %h", tap_state, TAP_TEST_LOGIC_RESET); end
    tests_run++; if (ir_value !== 10'h003) begin failures++; $display("FAIL tlr_ir got %h want 003", ir_value); end
    move(1'b0);
    tests_run++; if (tap_state !== TAP_RUN_TEST_IDLE) begin failures++; $display("FAIL tlr_to_rti got %h want %h", tap_state, TAP_RUN_TEST_IDLE); end
    tests_run++; if (tlr_cnt - tlr0 !== 1) begin failures++; $display("FAIL tlr_pulse_count got %0d want 1", tlr_cnt - tlr0); end
  endtask

  task automatic test_ir_capture_reset();
    logic b0, b1, o;
    logic [9:0] irt;
    int tlr0;
    load_ir(10'h020, irt);
    move(1'b1); move(1'b1); move(1'b0); move(1'b0);
    tck_cycle(1'b0, 1'b1, b0, o);
    tck_cycle(1'b0, 1'b1, b1, o);
    tests_run++; if ({b0, b1} !== 2'b10) begin failures++; $display("FAIL shift_ir_first_bits got %b%b want 10", b0, b1); end
    repeat (6) @(negedge clk);
    tests_run++; if (tap_state !== TAP_SHIFT_IR || jtag_bus.tdo_oe !== 1'b1) begin failures++; $display("FAIL mid_shift_ir got state=%h oe=%b want %h 1", tap_state, jtag_bus.tdo_oe, TAP_SHIFT_IR); end
    tlr0 = tlr_cnt;
    rst = 1'b1;
    @(negedge clk);
    tests_run++; if (tap_state !== TAP_TEST_LOGIC_RESET || ir_value !== 10'h003) begin failures++; $display("FAIL midreset_state got state=%h ir=%h want %h 003", tap_state, ir_value, TAP_TEST_LOGIC_RESET); end
    tests_run++; if ({jtag_bus.tdo, jtag_bus.tdo_oe, user_update_pulse, tlr_pulse} !== 4'b0000) begin failures++; $display("FAIL midreset_outputs got %b want 0000", {jtag_bus.tdo, jtag_bus.tdo_oe, user_update_pulse, tlr_pulse}); end
    tests_run++; if (user_update_data !== 32'h0) begin failures++; $display("FAIL midreset_user got %h want 0", user_update_data); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++; if (tlr_cnt - tlr0 !== 0) begin failures++; $display("FAIL midreset_tlr_pulse got %0d want 0", tlr_cnt - tlr0); end
    move(1'b0);
  endtask

`ifdef JTAG_TARGET_TRST_EN
  task automatic test_trst();
    logic [9:0] irt;
    int tlr0;
    load_ir(10'h3FF, irt);
    move(1'b1); move(1'b0); move(1'b0);
    tests_run++; if (tap_state !== TAP_SHIFT_DR) begin failures++; $display("FAIL trst_pre_state got %h want %h", tap_state, TAP_SHIFT_DR); end
    tlr0 = tlr_cnt;
    trst_n = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++; if (tap_state !== TAP_TEST_LOGIC_RESET || ir_value !== 10'h003) begin failures++; $display("FAIL trst_state got state=%h ir=%h want %h 003", tap_state, ir_value, TAP_TEST_LOGIC_RESET); end
    tests_run++; if (tlr_cnt - tlr0 !== 1) begin failures++; $display("FAIL trst_pulse_count got %0d want 1", tlr_cnt - tlr0); end
    trst_n = 1'b1;
    repeat (4) @(negedge clk);
    move(1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_idcode();
    test_bypass();
    test_user();
    test_tlr();
    test_ir_capture_reset();
`ifdef JTAG_TARGET_TRST_EN
    test_trst();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
